fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder buffer placed directly downstream of the last SDF butterfly stage.
//  Accepts the stage's natural-time, bit-reversed-index complex stream and re-emits each
//  FFT_N-point frame in natural bin order (bin 0 first).
//  Ping-pong buffered: one bank fills while the other drains, for continuous throughput.
// PARAMETERS
//  FFT_N   1024  points per frame; power of two, >= 4
//  LOG2N   10    log2(FFT_N); must match FFT_N
//  DATA_W  16    signed width of each real/imag component
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       input sample present (driven from the stage enable)
//  in_ready   out  1       buffer can accept a sample this cycle
//  in_re      in   DATA_W  signed real part from the last stage X_out_re
//  in_im      in   DATA_W  signed imag part from the last stage X_out_im
//  out_valid  out  1       out_re/out_im/out_idx hold a valid bin
//  out_ready  in   1       downstream accepts the bin
//  out_re     out  DATA_W  signed real part, natural order
//  out_im     out  DATA_W  signed imag part, natural order
//  out_idx    out  LOG2N   bin index of the current output (0..FFT_N-1)
//  out_last   out  1       high with bin FFT_N-1
// BEHAVIOUR
//  - Reset, asynchronous: wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full[1:0]=0.
//    Outputs after reset: out_valid=0, out_last=0, out_idx=0, out_re=0, out_im=0, in_ready=1.
//    RAM contents are not reset.
//  - Write side: a sample is accepted when in_valid && in_ready.
//    It is written at linear address wr_cnt of bank wr_bank, then wr_cnt increments.
//    When wr_cnt wraps from FFT_N-1 to 0: set full[wr_bank], toggle wr_bank.
//  - in_ready = !full[wr_bank]. While both banks are full, no input is accepted and data is not lost.
//  - Read side: active while full[rd_bank]=1. The RAM read address is bitrev(rd_cnt),
//    i.e. the LOG2N-bit reversal of rd_cnt.
//  - The RAM read is synchronous (1-cycle latency).
//    A 2-entry skid/output register decouples the RAM from out_ready, so sustained throughput is 1 bin/clk.
//  - When out_valid=1 and out_ready=0, out_re, out_im, out_idx and out_last hold stable.
//  - A bin is transferred when out_valid && out_ready. out_idx increments 0..FFT_N-1.
//  - After bin FFT_N-1 has been read from RAM: clear full[rd_bank], toggle rd_bank, rd_cnt=0.
//  - Latency: the first output bin has out_valid=1 two clk cycles after the clock edge
//    that accepted input sample FFT_N-1, provided the read bank is idle.
//  - Simultaneous set and clear of full[] bits: the write-wrap set and the read-done clear
//    may occur in the same cycle on different banks. Both take effect.
//    Same-bank set and clear cannot occur.
//  - Gapped input (in_valid deasserted mid-frame): wr_cnt holds and frame order is preserved.
//  - Gapped output (out_ready deasserted): no bin is skipped or duplicated.
//  - Reset asserted mid-frame: partial frames are discarded. The first frame after reset
//    starts at wr_cnt=0.
// STRUCTURE
//  - Shared header fft_defs.vh holds DATA_W, FFT_N/LOG2N defaults and a bitrev function
//    (generic LOG2N reversal). The twiddle and delay blocks reuse the same header.
//  - Sub-module fft_tpram: simple dual-port RAM, depth 2*FFT_N, width 2*DATA_W.
//    Address is {bank, index}. Synchronous read, one write port and one read port.
//  - This module contains the write counter, read counter, full flags and skid register.
// TESTING
//  - Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, and no RAM write is
//    counted after release.
//  - Single frame, FFT_N=8: inputs k=0..7 with re=k, im=-k arrive in order, so the input at
//    time k holds bin bitrev3(k). Required response: out_idx 0..7 with out_re=bitrev3(out_idx),
//    out_last only with idx 7, first out_valid 2 cycles after input 7.
//  - Back-to-back: 4 frames with in_valid=1 continuously and out_ready=1 ->
//    in_ready stays 1, there are no output bubbles after the first frame, and the data matches
//    the golden model.
//  - Backpressure: out_ready=0 for a full frame while input continues ->
//    in_ready falls to 0 exactly after the 2nd frame completes.
//    Releasing out_ready drains both frames intact.
//  - Random stall: random in_valid/out_ready at 50% over 20 frames, FFT_N=1024 ->
//    zero mismatches against the bit-reversal scoreboard.
//    out_* stays stable during every stall.
//  - Mid-frame reset: assert rst_n=0 after 5 inputs of a frame -> out_valid=0 immediately.
//    The next full frame after release is output correctly with out_idx starting at 0.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared definitions for the FFT output reorder path.
// Default frame geometry and the bit-reversal helper.
package fft_bitrev_reorder_pkg;

  localparam int FFT_N_DEF  = 1024;
  localparam int LOG2N_DEF  = 10;
  localparam int DATA_W_DEF = 16;
  localparam int BITREV_MAX = 16;

  // Reverses the low n bits of v; n may be 1..BITREV_MAX.
  function automatic logic [BITREV_MAX-1:0] bitrev(
    input logic [BITREV_MAX-1:0] v,
    input int                    n
  );
    logic [BITREV_MAX-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX - n);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_tpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Address is {bank, index}; contents are never reset.
module fft_tpram
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT stream in,
// natural bin order out, with a 2-entry output skid.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int FFT_N  = FFT_N_DEF,
  parameter int LOG2N  = LOG2N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_idx,
  output logic              out_last
);

  localparam int DW2 = 2 * DATA_W;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(FFT_N - 1);

  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_full;

  logic             r_rd_vld;
  logic [LOG2N-1:0] r_rd_idx;
  logic             r_rd_last;

  logic             r_out_vld;
  logic [DW2-1:0]   r_out_d;
  logic [LOG2N-1:0] r_out_idx;
  logic             r_out_last;
  logic             r_sk_vld;
  logic [DW2-1:0]   r_sk_d;
  logic [LOG2N-1:0] r_sk_idx;
  logic             r_sk_last;

  logic             w_wr_en;
  logic             w_wr_wrap;
  logic             w_rd_en;
  logic             w_rd_done;
  logic             w_pop;
  logic [1:0]       w_occ;
  logic [1:0]       w_set;
  logic [1:0]       w_clr;
  logic [LOG2N-1:0] w_rd_addr;
  logic [DW2-1:0]   w_rdata;

  assign in_ready  = !r_full[r_wr_bank];
  assign w_wr_en   = in_valid && in_ready;
  assign w_wr_wrap = w_wr_en && (r_wr_cnt == LAST);

  // Reads are issued only when the skid path can absorb them,
  // counting the word still in flight out of the RAM.
  assign w_pop     = r_out_vld && out_ready;
  assign w_occ     = 2'(r_out_vld) + 2'(r_sk_vld) + 2'(r_rd_vld);
  assign w_rd_en   = r_full[r_rd_bank] && ((w_occ < 2'd2) || w_pop);
  assign w_rd_done = w_rd_en && (r_rd_cnt == LAST);
  assign w_rd_addr = LOG2N'(bitrev(BITREV_MAX'(r_rd_cnt), LOG2N));

  assign w_set = w_wr_wrap ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  fft_tpram #(
    .AW (LOG2N + 1),
    .DW (DW2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, r_wr_cnt}),
    .i_wdata ({in_re, in_im}),
    .i_re    (w_rd_en),
    .i_raddr ({r_rd_bank, w_rd_addr}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_wrap) r_wr_bank <= !r_wr_bank;
      if (w_rd_en) r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + 1'b1;
      if (w_rd_done) r_rd_bank <= !r_rd_bank;
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_idx  <= r_rd_cnt;
        r_rd_last <= (r_rd_cnt == LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_d    <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
      r_sk_vld   <= 1'b0;
      r_sk_d     <= '0;
      r_sk_idx   <= '0;
      r_sk_last  <= 1'b0;
    end else if (w_pop || !r_out_vld) begin
      if (r_sk_vld) begin
        r_out_vld  <= 1'b1;
        r_out_d    <= r_sk_d;
        r_out_idx  <= r_sk_idx;
        r_out_last <= r_sk_last;
        r_sk_vld   <= r_rd_vld;
        if (r_rd_vld) begin
          r_sk_d    <= w_rdata;
          r_sk_idx  <= r_rd_idx;
          r_sk_last <= r_rd_last;
        end
      end else begin
        r_out_vld <= r_rd_vld;
        if (r_rd_vld) begin
          r_out_d    <= w_rdata;
          r_out_idx  <= r_rd_idx;
          r_out_last <= r_rd_last;
        end
      end
    end else if (r_rd_vld) begin
      r_sk_vld  <= 1'b1;
      r_sk_d    <= w_rdata;
      r_sk_idx  <= r_rd_idx;
      r_sk_last <= r_rd_last;
    end
  end

  assign out_valid = r_out_vld;
  assign out_re    = r_out_d[DW2-1:DATA_W];
  assign out_im    = r_out_d[DATA_W-1:0];
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for the 8-point reorder buffer.
// Driver pushes expected bins per completed frame; monitor pops.
module tb_fft_bitrev_reorder;

  localparam int N  = 8;
  localparam int LG = 3;
  localparam int DW = 16;
  localparam int BR8 [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [LG-1:0] out_idx;
  logic          out_last;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(
    .FFT_N  (N),
    .LOG2N  (LG),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [LG-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   xfer_cyc[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ser = 0;
  int   wpos = 0;
  int   fb [N];
  int   first_vld = -1;
  int   stall_acc = -1;
  int   n_acc = 0;
  int   acc_edge = 0;
  int   rmode = 0;
  bit   bp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic accept_sample();
    exp_t e;
    fb[wpos] = ser;
    wpos++;
    n_acc++;
    acc_edge = cyc + 1;
    ser++;
    if (wpos == N) begin
      for (int i = 0; i < N; i++) begin
        e.re   = DW'(fb[BR8[i]]);
        e.im   = DW'(-fb[BR8[i]]);
        e.idx  = LG'(i);
        e.last = (i == N - 1);
        sb.push_back(e);
      end
      wpos = 0;
    end
  endtask

  task automatic send(input int n, input int pct);
    int sent = 0;
    int bud = 0;
    while (sent < n && bud < n * 20 + 200) begin
      @(negedge clk);
      bud++;
      if ($urandom_range(99) < pct) begin
        in_valid = 1'b1;
        in_re    = DW'(ser);
        in_im    = DW'(-ser);
        if (in_ready) begin
          accept_sample();
          sent++;
        end else if (stall_acc < 0) begin
          stall_acc = n_acc;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("send_done", sent, n);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (sb.size() != 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(1) == 1);
    endcase
  end

  // Monitor: pops the scoreboard on every transfer, checks hold on stalls.
  initial begin
    exp_t e;
    bit   stalled;
    exp_t saved;
    stalled = 0;
    saved = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", {out_re, out_im, out_idx, out_last}, saved);
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && out_ready) begin
          xfer_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out_extra: idx %0d re %0h with empty scoreboard",
                     out_idx, out_re);
          end else begin
            e = sb.pop_front();
            chk("out_bin", {out_re, out_im, out_idx, out_last}, e);
          end
        end
        stalled = out_valid && !out_ready;
        saved = {out_re, out_im, out_idx, out_last};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int b;
    // reset with in_valid held high
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_re = 16'd99;
    in_im = 16'd99;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_last", out_last, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // single frame, re = k, im = -k
    rmode = 0;
    first_vld = -1;
    send(8, 100);
    wait_drain();
    chk("first_latency", first_vld - acc_edge, 2);

    // four frames back to back
    xfer_cyc.delete();
    stall_acc = -1;
    send(32, 100);
    wait_drain();
    chk("b2b_in_ready_low", stall_acc, -1);
    chk("b2b_xfers", xfer_cyc.size(), 32);
    if (xfer_cyc.size() >= 32)
      chk("b2b_bubbles", xfer_cyc[31] - xfer_cyc[8], 23);

    // backpressure for two frames
    rmode = 1;
    stall_acc = -1;
    base = n_acc;
    bp_done = 0;
    fork
      begin
        send(24, 100);
        bp_done = 1;
      end
    join_none
    repeat (40) @(negedge clk);
    chk("bp_stall_point", stall_acc - base, 16);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    rmode = 0;
    b = 0;
    while (!bp_done && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk("bp_send_done", bp_done, 1'b1);
    wait_drain();

    // random stalls on both sides, 20 frames
    rmode = 2;
    send(160, 50);
    wait_drain();
    rmode = 0;

    // reset in the middle of a frame
    rmode = 1;
    send(13, 100);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    wpos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rmode = 0;
    @(negedge clk);
    first_vld = -1;
    send(8, 100);
    wait_drain();
    chk("post_rst_latency", first_vld - acc_edge, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
